// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone burst-read data mover: fetches a word buffer from memory in
// incrementing bursts and pushes every word into the downstream stream FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | no transfer; busy/tx_cnt hold the result of the last transfer
// ST_WAIT  | transfer active, waiting for enough FIFO room for the next burst
// ST_BURST | bus cycle open, collecting beats until the last beat or an error

module wb_stream_writer_ctrl #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 5
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_wr,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic [WB_DW-1:0]     tx_cnt
);

    localparam int unsigned DEPTH   = 2**FIFO_AW;
    localparam logic [2:0]  CTI_INC = 3'b010;
    localparam logic [2:0]  CTI_EOB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [WB_AW-1:0]   r_start,    w_start_nxt;
    logic [WB_AW-1:0]   r_buf_size, w_buf_size_nxt;
    logic [WB_AW-1:0]   r_burst,    w_burst_nxt;
    logic [WB_AW-1:0]   r_tx_cnt,   w_tx_cnt_nxt;
    logic [WB_AW-1:0]   r_beats,    w_beats_nxt;
    logic [WB_AW-1:0]   r_adr,      w_adr_nxt;
    logic [2:0]         r_cti,      w_cti_nxt;
    logic               r_cyc,      w_cyc_nxt;
    logic [WB_DW-1:0]   r_fifo_d,   w_fifo_d_nxt;
    logic               r_fifo_wr,  w_fifo_wr_nxt;
    logic               r_busy,     w_busy_nxt;
    // Set on the way back from a burst: the final fifo_wr of that burst is
    // not yet visible in fifo_cnt, so the room check skips one cycle.
    logic               r_hold,     w_hold_nxt;

    logic [WB_AW-1:0]   w_rem;
    logic [WB_AW-1:0]   w_len;
    logic [WB_AW-1:0]   w_free;
    logic [WB_AW-1:0]   w_tx_inc;

    assign w_rem    = r_buf_size - r_tx_cnt;
    assign w_len    = (r_burst < w_rem) ? r_burst : w_rem;
    assign w_free   = WB_AW'(DEPTH) - WB_AW'(fifo_cnt);
    assign w_tx_inc = r_tx_cnt + WB_AW'(1);

    // Next-state and next-register values; everything holds unless changed.
    always_comb begin
        w_state_nxt    = r_state;
        w_start_nxt    = r_start;
        w_buf_size_nxt = r_buf_size;
        w_burst_nxt    = r_burst;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_beats_nxt    = r_beats;
        w_adr_nxt      = r_adr;
        w_cti_nxt      = r_cti;
        w_cyc_nxt      = r_cyc;
        w_fifo_d_nxt   = r_fifo_d;
        w_fifo_wr_nxt  = 1'b0;
        w_busy_nxt     = r_busy;
        w_hold_nxt     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (enable && (buf_size != '0)) begin
                    w_start_nxt    = start_adr;
                    w_buf_size_nxt = buf_size;
                    w_burst_nxt    = (burst_size == '0) ? WB_AW'(1) : burst_size;
                    w_tx_cnt_nxt   = '0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!r_hold && (w_free >= w_len)) begin
                    w_cyc_nxt   = 1'b1;
                    w_adr_nxt   = r_start + (r_tx_cnt << 2);
                    w_cti_nxt   = (w_len == WB_AW'(1)) ? CTI_EOB : CTI_INC;
                    w_beats_nxt = w_len;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wbm_err_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_cti_nxt   = 3'b000;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (wbm_ack_i) begin
                    w_fifo_d_nxt  = wbm_dat_i;
                    w_fifo_wr_nxt = 1'b1;
                    w_adr_nxt     = r_adr + WB_AW'(4);
                    w_tx_cnt_nxt  = w_tx_inc;
                    w_beats_nxt   = r_beats - WB_AW'(1);
                    if (r_beats == WB_AW'(1)) begin
                        w_cyc_nxt = 1'b0;
                        w_cti_nxt = 3'b000;
                        if (w_tx_inc == r_buf_size) begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_hold_nxt  = 1'b1;
                            w_state_nxt = ST_WAIT;
                        end
                    end else if (r_beats == WB_AW'(2)) begin
                        w_cti_nxt = CTI_EOB;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears the bus cycle immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_start    <= '0;
            r_buf_size <= '0;
            r_burst    <= '0;
            r_tx_cnt   <= '0;
            r_beats    <= '0;
            r_adr      <= '0;
            r_cti      <= 3'b000;
            r_cyc      <= 1'b0;
            r_fifo_d   <= '0;
            r_fifo_wr  <= 1'b0;
            r_busy     <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_start    <= w_start_nxt;
            r_buf_size <= w_buf_size_nxt;
            r_burst    <= w_burst_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_beats    <= w_beats_nxt;
            r_adr      <= w_adr_nxt;
            r_cti      <= w_cti_nxt;
            r_cyc      <= w_cyc_nxt;
            r_fifo_d   <= w_fifo_d_nxt;
            r_fifo_wr  <= w_fifo_wr_nxt;
            r_busy     <= w_busy_nxt;
            r_hold     <= w_hold_nxt;
        end
    end

    assign wbm_adr_o = r_adr;
    assign wbm_sel_o = {(WB_DW/8){r_cyc}};
    assign wbm_we_o  = 1'b0;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_cti_o = r_cti;
    assign wbm_bte_o = 2'b00;
    assign fifo_d    = r_fifo_d;
    assign fifo_wr   = r_fifo_wr;
    assign busy      = r_busy;
    assign tx_cnt    = WB_DW'(r_tx_cnt);

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Scoreboard bench for wb_stream_writer_ctrl: expected bus beats and FIFO
// words are queued by the directed tests and consumed by a negedge monitor.

module tb_wb_stream_writer_ctrl;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int FIFO_AW = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [WB_AW-1:0]   adr;
    logic [3:0]         sel;
    logic               we, cyc, stb;
    logic [2:0]         cti;
    logic [1:0]         bte;
    logic [WB_DW-1:0]   dat;
    logic               ack, err;
    logic [WB_DW-1:0]   fifo_d;
    logic               fifo_wr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               enable;
    logic [WB_AW-1:0]   start_adr, buf_size, burst_size;
    logic               busy;
    logic [WB_DW-1:0]   tx_cnt;

    wb_stream_writer_ctrl #(.WB_AW(WB_AW), .WB_DW(WB_DW), .FIFO_AW(FIFO_AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_o(adr), .wbm_sel_o(sel), .wbm_we_o(we), .wbm_cyc_o(cyc),
        .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte), .wbm_dat_i(dat),
        .wbm_ack_i(ack), .wbm_err_i(err),
        .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt),
        .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
        .burst_size(burst_size), .busy(busy), .tx_cnt(tx_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    beat_t        q_beat[$];
    logic [31:0]  q_fifo[$];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int last_ack_cyc = 0;
    int done_cyc = 0;
    int stall_n = 0;
    int err_beat = -1;
    int beat_idx = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic push_beat(input logic [31:0] a, input logic [2:0] c, input bit to_fifo);
        beat_t b;
        b.adr = a;
        b.cti = c;
        q_beat.push_back(b);
        if (to_fifo) q_fifo.push_back(mem(a));
    endtask

    always @(posedge clk) cyc_n++;

    // Wishbone slave: optional wait states per beat and an error on a chosen beat.
    initial begin
        int stall_cnt;
        ack = 1'b0;
        err = 1'b0;
        dat = '0;
        stall_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !cyc) begin
                ack = 1'b0;
                err = 1'b0;
                stall_cnt = 0;
            end else if (stall_cnt < stall_n) begin
                ack = 1'b0;
                err = 1'b0;
                stall_cnt++;
            end else begin
                stall_cnt = 0;
                if (beat_idx == err_beat) begin
                    err = 1'b1;
                    ack = 1'b0;
                end else begin
                    ack = 1'b1;
                    err = 1'b0;
                    dat = mem(adr);
                end
                beat_idx++;
            end
        end
    end

    // Monitor: bus beats and FIFO writes are checked against the queues.
    always @(negedge clk) begin
        if (cyc) begin
            if (q_beat.size() == 0) begin
                chk("unexpected_beat", adr, 32'hFFFF_FFFF);
            end else begin
                chk("beat_adr", adr, q_beat[0].adr);
                chk("beat_cti", {29'd0, cti}, {29'd0, q_beat[0].cti});
                chk("beat_sel_we_stb", {27'd0, sel, we}, {27'd0, 4'hF, 1'b0});
                chk("stb_eq_cyc", {31'd0, stb}, 32'd1);
                if (ack || err) begin
                    last_ack_cyc = cyc_n;
                    void'(q_beat.pop_front());
                end
            end
        end
        if (fifo_wr) begin
            if (q_fifo.size() == 0) begin
                chk("unexpected_fifo_wr", fifo_d, 32'hFFFF_FFFF);
            end else begin
                chk("fifo_d", fifo_d, q_fifo.pop_front());
            end
        end
    end

    task automatic pulse_en(input logic [31:0] s, input logic [31:0] b, input logic [31:0] bs);
        @(negedge clk);
        enable = 1'b1;
        start_adr = s;
        buf_size = b;
        burst_size = bs;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
        done_cyc = cyc_n;
    endtask

    task automatic queues_empty(input string name);
        @(negedge clk);
        chk({name, "_beats_left"}, q_beat.size(), 0);
        chk({name, "_words_left"}, q_fifo.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        start_adr = '0;
        buf_size = '0;
        burst_size = '0;
        fifo_cnt = '0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_cnt", tx_cnt, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        rst = 1'b0;

        // 1: eight words in two bursts of four, FIFO empty, zero wait states
        beat_idx = 0;
        push_beat(32'h1000, 3'b010, 1); push_beat(32'h1004, 3'b010, 1);
        push_beat(32'h1008, 3'b010, 1); push_beat(32'h100C, 3'b111, 1);
        push_beat(32'h1010, 3'b010, 1); push_beat(32'h1014, 3'b010, 1);
        push_beat(32'h1018, 3'b010, 1); push_beat(32'h101C, 3'b111, 1);
        pulse_en(32'h1000, 32'd8, 32'd4);
        chk("t1_busy_n1", {31'd0, busy}, 32'd1);
        chk("t1_cyc_n1", {31'd0, cyc}, 32'd0);
        @(negedge clk);
        chk("t1_cyc_n2", {31'd0, cyc}, 32'd1);
        wait_done("t1");
        chk("t1_busy_fall", done_cyc, last_ack_cyc + 1);
        chk("t1_tx_cnt", tx_cnt, 32'd8);
        queues_empty("t1");

        // 2: five words, burst four then a single beat
        beat_idx = 0;
        push_beat(32'h1000, 3'b010, 1); push_beat(32'h1004, 3'b010, 1);
        push_beat(32'h1008, 3'b010, 1); push_beat(32'h100C, 3'b111, 1);
        push_beat(32'h1010, 3'b111, 1);
        pulse_en(32'h1000, 32'd5, 32'd4);
        wait_done("t2");
        chk("t2_tx_cnt", tx_cnt, 32'd5);
        queues_empty("t2");

        // 3: FIFO room gating, depth 8
        beat_idx = 0;
        fifo_cnt = 4'd6;
        push_beat(32'h7000, 3'b010, 1); push_beat(32'h7004, 3'b010, 1);
        push_beat(32'h7008, 3'b010, 1); push_beat(32'h700C, 3'b111, 1);
        pulse_en(32'h7000, 32'd4, 32'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_no_cyc", {31'd0, cyc}, 32'd0);
        end
        fifo_cnt = 4'd4;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                if (cyc) seen = 1'b1;
                if (seen) break;
            end
            chk("t3_cyc_within_2", {31'd0, seen}, 32'd1);
        end
        wait_done("t3");
        chk("t3_tx_cnt", tx_cnt, 32'd4);
        fifo_cnt = '0;
        queues_empty("t3");

        // 4: three wait states per beat
        beat_idx = 0;
        stall_n = 3;
        push_beat(32'h3000, 3'b010, 1); push_beat(32'h3004, 3'b111, 1);
        push_beat(32'h3008, 3'b010, 1); push_beat(32'h300C, 3'b111, 1);
        pulse_en(32'h3000, 32'd4, 32'd2);
        wait_done("t4");
        chk("t4_tx_cnt", tx_cnt, 32'd4);
        stall_n = 0;
        queues_empty("t4");

        // 5: bus error on the second beat of the first burst
        beat_idx = 0;
        err_beat = 1;
        push_beat(32'h6000, 3'b010, 1); push_beat(32'h6004, 3'b010, 0);
        pulse_en(32'h6000, 32'd8, 32'd4);
        wait_done("t5");
        chk("t5_busy_fall", done_cyc, last_ack_cyc + 1);
        chk("t5_cyc_dropped", {31'd0, cyc}, 32'd0);
        chk("t5_tx_cnt", tx_cnt, 32'd1);
        err_beat = -1;
        queues_empty("t5");

        // 6a: enable while busy is ignored, enable with zero length is ignored
        beat_idx = 0;
        stall_n = 2;
        push_beat(32'h4000, 3'b010, 1); push_beat(32'h4004, 3'b010, 1);
        push_beat(32'h4008, 3'b010, 1); push_beat(32'h400C, 3'b111, 1);
        pulse_en(32'h4000, 32'd4, 32'd4);
        repeat (3) @(negedge clk);
        pulse_en(32'h9000, 32'd2, 32'd1);
        wait_done("t6a");
        chk("t6a_tx_cnt", tx_cnt, 32'd4);
        stall_n = 0;
        queues_empty("t6a");
        pulse_en(32'hA000, 32'd0, 32'd4);
        chk("t6a_zero_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t6a_zero_cyc", {31'd0, cyc}, 32'd0);
        chk("t6a_tx_held", tx_cnt, 32'd4);

        // 6b: reset in the middle of a burst
        beat_idx = 0;
        stall_n = 3;
        push_beat(32'h5000, 3'b010, 1); push_beat(32'h5004, 3'b010, 1);
        push_beat(32'h5008, 3'b010, 1); push_beat(32'h500C, 3'b010, 1);
        push_beat(32'h5010, 3'b010, 1); push_beat(32'h5014, 3'b010, 1);
        push_beat(32'h5018, 3'b010, 1); push_beat(32'h501C, 3'b111, 1);
        pulse_en(32'h5000, 32'd8, 32'd8);
        begin
            int i;
            for (i = 0; i < 20; i++) begin
                if (cyc) break;
                @(negedge clk);
            end
            chk("t6b_cyc_started", {31'd0, cyc}, 32'd1);
        end
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6b_rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        chk("t6b_rst_adr", adr, 32'd0);
        chk("t6b_rst_cti_sel", {25'd0, cti, sel}, 32'd0);
        chk("t6b_rst_fifo", {fifo_d[30:0], fifo_wr}, 32'd0);
        chk("t6b_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6b_rst_tx_cnt", tx_cnt, 32'd0);
        q_beat.delete();
        q_fifo.delete();
        stall_n = 0;
        @(negedge clk);
        rst = 1'b0;

        // 7: single word with burst_size 0 (treated as 1) after reset
        beat_idx = 0;
        push_beat(32'h8000, 3'b111, 1);
        pulse_en(32'h8000, 32'd1, 32'd0);
        wait_done("t7");
        chk("t7_tx_cnt", tx_cnt, 32'd1);
        queues_empty("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
